// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared widths, owner tag encodings and starvation default
// for the video RAM arbiter slice.
package vram_arbiter_pkg;
  localparam int VA_ADDR_W = 16;
  localparam int VA_DATA_W = 8;
  localparam int VA_MAX_WAIT = 1023;
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_A = 2'd2;
  localparam logic [1:0] TAG_B = 2'd3;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: one client port of the video RAM arbiter.
// master: client side (drives req/we/addr/wdata, sees ack/rvalid/rdata/starve)
// slave:  arbiter side
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = VA_ADDR_W,
  parameter int DATA_W = VA_DATA_W
);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic ack;
  logic rvalid;
  logic [DATA_W-1:0] rdata;
  logic starve;
  modport master (output req, we, addr, wdata, input ack, rvalid, rdata, starve);
  modport slave (input req, we, addr, wdata, output ack, rvalid, rdata, starve);
endinterface

// File: rtl/vram_arbiter_starve_monitor.sv
// vram_arbiter_starve_monitor: saturating per-client wait counter with a sticky
// starve flag.
// Ports: clk, rst (async, active-high); req/ack from the client handshake;
// frame clears the flag; starve is the sticky flag.
module vram_arbiter_starve_monitor
  import vram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = VA_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  input  logic frame,
  output logic starve
);
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic set;
  always_comb begin
    cnt_nxt = (req && !ack) ? ((cnt == 16'hffff) ? cnt : cnt + 16'd1) : 16'd0;
    set = req && !ack && (cnt_nxt == 16'(MAX_WAIT));
  end
  // a set in the same cycle as a frame clear wins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      starve <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      starve <= set || (starve && !frame);
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video RAM arbiter for display scan-out and two clients.
// Ports: clk, rst (async, active-high); data_enable/frame from the timing
// generator; disp_re/disp_addr -> disp_rvalid/disp_rdata display read path;
// a, b client interfaces (slave modport); ram_en/ram_we/ram_addr/ram_wdata
// registered RAM command; ram_rdata RAM data one cycle after ram_en.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = VA_ADDR_W,
  parameter int DATA_W = VA_DATA_W,
  parameter int PROTECT_ACTIVE = 1,
  parameter int MAX_WAIT = VA_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic data_enable,
  input  logic frame,
  input  logic disp_re,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  vram_arbiter_if.slave a,
  vram_arbiter_if.slave b,
  output logic ram_en,
  output logic ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic rr_a;
  logic el_a;
  logic el_b;
  logic g_a;
  logic g_b;
  logic [1:0] tag_cmd;
  logic [1:0] tag1;
  logic [1:0] tag2;
  logic [DATA_W-1:0] d_hold;
  logic [DATA_W-1:0] a_hold;
  logic [DATA_W-1:0] b_hold;
  // writes are held off during active video; reads are always eligible
  always_comb begin
    el_a = a.req && !(PROTECT_ACTIVE != 0 && a.we && data_enable);
    el_b = b.req && !(PROTECT_ACTIVE != 0 && b.we && data_enable);
    g_a = !disp_re && el_a && (rr_a || !el_b);
    g_b = !disp_re && el_b && !g_a;
    tag_cmd = disp_re ? TAG_DISP : (g_a && !a.we) ? TAG_A : (g_b && !b.we) ? TAG_B : TAG_NONE;
  end
  assign a.ack = g_a;
  assign b.ack = g_b;
  assign disp_rvalid = tag2 == TAG_DISP;
  assign a.rvalid = tag2 == TAG_A;
  assign b.rvalid = tag2 == TAG_B;
  // rdata follows the RAM during the valid pulse and holds the last word after
  assign disp_rdata = disp_rvalid ? ram_rdata : d_hold;
  assign a.rdata = a.rvalid ? ram_rdata : a_hold;
  assign b.rdata = b.rvalid ? ram_rdata : b_hold;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_a <= 1'b1;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      tag1 <= TAG_NONE;
      tag2 <= TAG_NONE;
      d_hold <= '0;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      rr_a <= frame ? 1'b1 : g_a ? 1'b0 : g_b ? 1'b1 : rr_a;
      ram_en <= disp_re || g_a || g_b;
      ram_we <= g_a ? a.we : g_b && b.we;
      ram_addr <= disp_re ? disp_addr : g_a ? a.addr : b.addr;
      ram_wdata <= g_a ? a.wdata : b.wdata;
      tag1 <= tag_cmd;
      tag2 <= tag1;
      d_hold <= disp_rdata;
      a_hold <= a.rdata;
      b_hold <= b.rdata;
    end
  vram_arbiter_starve_monitor #(.MAX_WAIT(MAX_WAIT)) u_starve_a (
    .clk(clk), .rst(rst), .req(a.req), .ack(g_a), .frame(frame), .starve(a.starve)
  );
  vram_arbiter_starve_monitor #(.MAX_WAIT(MAX_WAIT)) u_starve_b (
    .clk(clk), .rst(rst), .req(b.req), .ack(g_b), .frame(frame), .starve(b.starve)
  );
endmodule
